// File: rtl/dram_scheduler_types.sv
// Shared command encodings, FSM states and default DRAM timing values
// for the timed command scheduler.
package dram_scheduler_types;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_PRE = 3'd2,
    CMD_RD  = 3'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EMIT_PRE,
    ST_EMIT_ACT,
    ST_EMIT_RD,
    ST_HOLD
  } state_e;

  localparam int DEF_T_RCD   = 4;
  localparam int DEF_T_RP    = 4;
  localparam int DEF_T_RTP   = 2;
  localparam int DEF_T_RRD_S = 2;
  localparam int DEF_T_RRD_L = 3;
  localparam int DEF_T_CCD_S = 2;
  localparam int DEF_T_CCD_L = 4;
  localparam int DEF_T_FAW   = 16;

  // A four-activate window looks back exactly four ACTs.
  localparam int FAW_DEPTH = 4;

endpackage

// File: rtl/timed_cmd_scheduler_if.sv
// Request and command handshake bundle of the timed command scheduler.
// master = request source / command sink, slave = the scheduler.
interface timed_cmd_scheduler_if #(
  parameter int NUM_BG       = 4,
  parameter int BANKS_PER_BG = 4,
  parameter int ROW_W        = 16,
  parameter int COL_W        = 10,
  parameter int ID_W         = 8,
  parameter int CYC_W        = 16
);
  localparam int BG_W = $clog2(NUM_BG);
  localparam int BK_W = $clog2(BANKS_PER_BG);

  logic             in_valid;
  logic             in_ready;
  logic [BG_W-1:0]  in_bg;
  logic [BK_W-1:0]  in_bank;
  logic [ROW_W-1:0] in_row;
  logic [COL_W-1:0] in_col;
  logic [ID_W-1:0]  in_req_id;

  logic             out_valid;
  logic             out_ready;
  logic [CYC_W-1:0] out_cycle;
  logic [2:0]       out_cmd;
  logic [BG_W-1:0]  out_bg;
  logic [BK_W-1:0]  out_bank;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic [ID_W-1:0]  out_req_id;

  modport master (
    output in_valid, in_bg, in_bank, in_row, in_col, in_req_id, out_ready,
    input  in_ready, out_valid, out_cycle, out_cmd, out_bg, out_bank,
           out_row, out_col, out_req_id
  );

  modport slave (
    input  in_valid, in_bg, in_bank, in_row, in_col, in_req_id, out_ready,
    output in_ready, out_valid, out_cycle, out_cmd, out_bg, out_bank,
           out_row, out_col, out_req_id
  );
endinterface

// File: rtl/act_window_tracker.sv
// Remembers the stamps of the last four ACT commands; o_oldest is the
// fourth-most-recent one and is meaningful once o_full is set.
module act_window_tracker
  import dram_scheduler_types::*;
#(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [CYC_W-1:0] i_stamp,
  output logic [CYC_W-1:0] o_oldest,
  output logic             o_full
);
  logic [CYC_W-1:0] r_hist [FAW_DEPTH];
  logic [2:0]       r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_push && (r_cnt != 3'(FAW_DEPTH))) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // NOTE: the history array carries no reset; r_cnt says which entries are real.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_hist[0] <= i_stamp;
      for (int i = 1; i < FAW_DEPTH; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  assign o_oldest = r_hist[FAW_DEPTH-1];
  assign o_full   = (r_cnt == 3'(FAW_DEPTH));
endmodule

// File: rtl/timed_cmd_scheduler.sv
// Turns read requests into time-stamped PRE/ACT/RD commands honouring bank
// timing. Define SCHED_FAW_EN to add the four-activate-window constraint.
module timed_cmd_scheduler
  import dram_scheduler_types::*;
#(
  parameter int NUM_BG       = 4,
  parameter int BANKS_PER_BG = 4,
  parameter int ROW_W        = 16,
  parameter int COL_W        = 10,
  parameter int ID_W         = 8,
  parameter int CYC_W        = 16,
  parameter int T_RCD        = DEF_T_RCD,
  parameter int T_RP         = DEF_T_RP,
  parameter int T_RTP        = DEF_T_RTP,
  parameter int T_RRD_S      = DEF_T_RRD_S,
  parameter int T_RRD_L      = DEF_T_RRD_L,
  parameter int T_CCD_S      = DEF_T_CCD_S,
  parameter int T_CCD_L      = DEF_T_CCD_L,
  parameter int T_FAW        = DEF_T_FAW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  timed_cmd_scheduler_if.slave bus,
  output logic                 busy,
  output logic                 time_ovf
);
  localparam int BG_W      = $clog2(NUM_BG);
  localparam int BK_W      = $clog2(BANKS_PER_BG);
  localparam int NUM_BANKS = NUM_BG * BANKS_PER_BG;
  localparam int IDX_W     = $clog2(NUM_BANKS);

  typedef struct packed {
    logic [BG_W-1:0]  bg;
    logic [BK_W-1:0]  bank;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ID_W-1:0]  id;
  } req_t;

  // Sums are one bit wider than a stamp so overflow is visible before saturation.
  function automatic logic [CYC_W:0] plus(input logic [CYC_W-1:0] base, input int dly);
    return {1'b0, base} + (CYC_W+1)'(dly);
  endfunction

  function automatic logic [CYC_W:0] max2(input logic [CYC_W:0] a, input logic [CYC_W:0] b);
    return (a > b) ? a : b;
  endfunction

  state_e r_state, w_state_nxt, r_after_hold;
  req_t   r_req, w_in_req;
  logic   [IDX_W-1:0] w_idx;
  logic   w_accept, w_emit;

  logic             r_open    [NUM_BANKS];
  logic             r_pre_vld [NUM_BANKS];
  logic             r_rd_vld  [NUM_BANKS];
  logic [ROW_W-1:0] r_bank_row[NUM_BANKS];
  logic [CYC_W-1:0] r_bank_act[NUM_BANKS];
  logic [CYC_W-1:0] r_bank_pre[NUM_BANKS];
  logic [CYC_W-1:0] r_bank_rd [NUM_BANKS];

  logic             r_any_cmd, r_act_any, r_rd_any, r_time_ovf;
  logic [CYC_W-1:0] r_last, r_last_act, r_last_rd;
  logic [BG_W-1:0]  r_last_act_bg, r_last_rd_bg;
  logic [CYC_W:0]   w_floor, w_raw;
  logic [CYC_W-1:0] w_stamp;

  logic             r_out_valid;
  cmd_e             r_out_cmd;
  logic [CYC_W-1:0] r_out_cycle;
  logic [BG_W-1:0]  r_out_bg;
  logic [BK_W-1:0]  r_out_bank;
  logic [ROW_W-1:0] r_out_row;
  logic [COL_W-1:0] r_out_col;
  logic [ID_W-1:0]  r_out_id;

  assign w_in_req = '{bg: bus.in_bg, bank: bus.in_bank, row: bus.in_row,
                      col: bus.in_col, id: bus.in_req_id};
  assign w_idx    = IDX_W'(int'(r_req.bg) * BANKS_PER_BG + int'(r_req.bank));
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_emit   = (r_state inside {ST_EMIT_PRE, ST_EMIT_ACT, ST_EMIT_RD}) && !clear;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: defaults first keep this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (w_accept) w_state_nxt = ST_CHECK;
        ST_CHECK: begin
          if (!r_open[w_idx])                   w_state_nxt = ST_EMIT_ACT;
          else if (r_bank_row[w_idx] == r_req.row) w_state_nxt = ST_EMIT_RD;
          else                                  w_state_nxt = ST_EMIT_PRE;
        end
        ST_EMIT_PRE, ST_EMIT_ACT, ST_EMIT_RD: w_state_nxt = ST_HOLD;
        ST_HOLD:  if (bus.out_ready) w_state_nxt = r_after_hold;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------- stamps
`ifdef SCHED_FAW_EN
  logic [CYC_W-1:0] w_faw_oldest;
  logic             w_faw_full;

  act_window_tracker #(.CYC_W(CYC_W)) u_act_window (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (clear),
    .i_push   (w_emit && (r_state == ST_EMIT_ACT)),
    .i_stamp  (w_stamp),
    .o_oldest (w_faw_oldest),
    .o_full   (w_faw_full)
  );
`else
  // T_FAW only takes effect when the window tracker is compiled in.
  if (T_FAW < 0) begin : g_faw_unused
  end
`endif

  assign w_floor = r_any_cmd ? plus(r_last, 1) : '0;

  always_comb begin
    w_raw = w_floor;
    unique case (r_state)
      ST_EMIT_PRE: begin
        if (r_rd_vld[w_idx]) w_raw = max2(w_raw, plus(r_bank_rd[w_idx], T_RTP));
      end
      ST_EMIT_ACT: begin
        if (r_pre_vld[w_idx]) w_raw = max2(w_raw, plus(r_bank_pre[w_idx], T_RP));
        if (r_act_any)
          w_raw = max2(w_raw, plus(r_last_act, (r_last_act_bg == r_req.bg) ? T_RRD_L : T_RRD_S));
`ifdef SCHED_FAW_EN
        if (w_faw_full) w_raw = max2(w_raw, plus(w_faw_oldest, T_FAW));
`endif
      end
      ST_EMIT_RD: begin
        w_raw = max2(w_raw, plus(r_bank_act[w_idx], T_RCD));
        if (r_rd_any)
          w_raw = max2(w_raw, plus(r_last_rd, (r_last_rd_bg == r_req.bg) ? T_CCD_L : T_CCD_S));
      end
      default: ;
    endcase
  end

  assign w_stamp = w_raw[CYC_W] ? '1 : w_raw[CYC_W-1:0];

  // --------------------------------------- control state and outputs
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_out_valid   <= 1'b0;
      r_out_cmd     <= CMD_NOP;
      r_out_cycle   <= '0;
      r_out_bg      <= '0;
      r_out_bank    <= '0;
      r_out_row     <= '0;
      r_out_col     <= '0;
      r_out_id      <= '0;
      r_after_hold  <= ST_IDLE;
      r_any_cmd     <= 1'b0;
      r_act_any     <= 1'b0;
      r_rd_any      <= 1'b0;
      r_last        <= '0;
      r_last_act    <= '0;
      r_last_rd     <= '0;
      r_last_act_bg <= '0;
      r_last_rd_bg  <= '0;
      r_time_ovf    <= 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_open[i]    <= 1'b0;
        r_pre_vld[i] <= 1'b0;
        r_rd_vld[i]  <= 1'b0;
      end
    end else begin
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_cycle <= w_stamp;
        r_out_bg    <= r_req.bg;
        r_out_bank  <= r_req.bank;
        r_out_col   <= r_req.col;
        r_out_id    <= r_req.id;
        r_out_row   <= '0;
        r_last      <= w_stamp;
        r_any_cmd   <= 1'b1;
        if (w_raw[CYC_W]) r_time_ovf <= 1'b1;
        unique case (r_state)
          ST_EMIT_PRE: begin
            r_out_cmd        <= CMD_PRE;
            r_open[w_idx]    <= 1'b0;
            r_pre_vld[w_idx] <= 1'b1;
            r_after_hold     <= ST_EMIT_ACT;
          end
          ST_EMIT_ACT: begin
            r_out_cmd      <= CMD_ACT;
            r_out_row      <= r_req.row;
            r_open[w_idx]  <= 1'b1;
            r_act_any      <= 1'b1;
            r_last_act     <= w_stamp;
            r_last_act_bg  <= r_req.bg;
            r_after_hold   <= ST_EMIT_RD;
          end
          default: begin
            r_out_cmd       <= CMD_RD;
            r_rd_vld[w_idx] <= 1'b1;
            r_rd_any        <= 1'b1;
            r_last_rd       <= w_stamp;
            r_last_rd_bg    <= r_req.bg;
            r_after_hold    <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // NOTE: bank rows/stamps need no reset; the open/valid flags gate every use.
  always_ff @(posedge clk) begin
    if (w_accept) r_req <= w_in_req;
    if (w_emit) begin
      unique case (r_state)
        ST_EMIT_PRE: r_bank_pre[w_idx] <= w_stamp;
        ST_EMIT_ACT: begin
          r_bank_act[w_idx] <= w_stamp;
          r_bank_row[w_idx] <= r_req.row;
        end
        default:     r_bank_rd[w_idx] <= w_stamp;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == ST_IDLE) && !clear;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_cmd    = r_out_cmd;
  assign bus.out_cycle  = r_out_cycle;
  assign bus.out_bg     = r_out_bg;
  assign bus.out_bank   = r_out_bank;
  assign bus.out_row    = r_out_row;
  assign bus.out_col    = r_out_col;
  assign bus.out_req_id = r_out_id;
  assign busy           = (r_state != ST_IDLE);
  assign time_ovf       = r_time_ovf;
endmodule

// File: tb/tb_timed_cmd_scheduler.sv
// Directed bench for timed_cmd_scheduler: row hit/conflict/closed sequences,
// bank-group spacing, four-activate window, backpressure and clear.
module tb_timed_cmd_scheduler;
  import dram_scheduler_types::*;

`ifdef SCHED_FAW_EN
  localparam int FIFTH_ACT = 30;
  localparam int FIFTH_RD  = 34;
  localparam int HELD_ACT  = 35;
`else
  localparam int FIFTH_ACT = 20;
  localparam int FIFTH_RD  = 24;
  localparam int HELD_ACT  = 25;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic busy;
  logic time_ovf;

  always #5 clk = ~clk;

  timed_cmd_scheduler_if bus ();

  timed_cmd_scheduler #(.T_FAW(30)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bus      (bus),
    .busy     (busy),
    .time_ovf (time_ovf)
  );

  typedef struct {
    logic [2:0] cmd;
    int cyc, bg, bank, row, col, id;
  } cmd_rec_t;

  cmd_rec_t q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Record every command handshake; inputs settle 1ns after posedge, so the
  // negedge sees exactly what the next posedge will.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      q.push_back('{cmd: bus.out_cmd, cyc: int'(bus.out_cycle), bg: int'(bus.out_bg),
                    bank: int'(bus.out_bank), row: int'(bus.out_row),
                    col: int'(bus.out_col), id: int'(bus.out_req_id)});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
  endtask

  task automatic send_rd(input int bg, input int bank, input int row, input int col, input int id);
    int n = 0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_bg     = 2'(bg);
    bus.in_bank   = 2'(bank);
    bus.in_row    = 16'(row);
    bus.in_col    = 10'(col);
    bus.in_req_id = 8'(id);
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic expect_cmd(input string tag, input logic [2:0] cmd, input int cyc,
                            input int bg, input int bank, input int row,
                            input int col, input int id, input bit chk_ci);
    cmd_rec_t r;
    check({tag, ".avail"}, (q.size() != 0) ? 64'd1 : 64'd0, 64'd1);
    if (q.size() == 0) return;
    r = q.pop_front();
    check({tag, ".cmd"},  r.cmd,  cmd);
    check({tag, ".cyc"},  r.cyc,  cyc);
    check({tag, ".bg"},   r.bg,   bg);
    check({tag, ".bank"}, r.bank, bank);
    check({tag, ".row"},  r.row,  row);
    if (chk_ci) begin
      check({tag, ".col"}, r.col, col);
      check({tag, ".id"},  r.id,  id);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_act[5] = '{0, 5, 10, 15, FIFTH_ACT};
    int exp_rd[5]  = '{4, 9, 14, 19, FIFTH_RD};
    int n;

    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bg     = '0;
    bus.in_bank   = '0;
    bus.in_row    = '0;
    bus.in_col    = '0;
    bus.in_req_id = '0;
    bus.out_ready = 1'b1;
    do_reset();

    check("rst.in_ready",  bus.in_ready, 1);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.out_cmd",   bus.out_cmd, 0);
    check("rst.out_cycle", bus.out_cycle, 0);
    check("rst.out_row",   bus.out_row, 0);
    check("rst.out_id",    bus.out_req_id, 0);
    check("rst.busy",      busy, 0);
    check("rst.time_ovf",  time_ovf, 0);

    // Closed bank: ACT then RD.
    send_rd(0, 0, 5, 3, 1);
    wait_idle();
    expect_cmd("t1.act", CMD_ACT, 0, 0, 0, 5, 0, 0, 1'b0);
    expect_cmd("t1.rd",  CMD_RD,  4, 0, 0, 0, 3, 1, 1'b1);
    check("t1.extra", q.size(), 0);

    // Row hit, same bank group: long CCD only.
    send_rd(0, 0, 5, 7, 2);
    wait_idle();
    expect_cmd("t2.rd", CMD_RD, 8, 0, 0, 0, 7, 2, 1'b1);
    check("t2.extra", q.size(), 0);

    // Row conflict: PRE after RTP, ACT after RP, RD after RCD.
    send_rd(0, 0, 9, 0, 3);
    wait_idle();
    expect_cmd("t3.pre", CMD_PRE, 10, 0, 0, 0, 0, 0, 1'b0);
    expect_cmd("t3.act", CMD_ACT, 14, 0, 0, 9, 0, 0, 1'b0);
    expect_cmd("t3.rd",  CMD_RD,  18, 0, 0, 0, 0, 3, 1'b1);
    check("t3.extra", q.size(), 0);

    // Five activates across bank groups; the fifth is the window boundary.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_rd(i % 4, (i == 4) ? 1 : 0, 1, i, 10 + i);
      wait_idle();
    end
    for (int i = 0; i < 5; i++) begin
      expect_cmd($sformatf("t4.act%0d", i), CMD_ACT, exp_act[i], i % 4, (i == 4) ? 1 : 0, 1, 0, 0, 1'b0);
      expect_cmd($sformatf("t4.rd%0d", i),  CMD_RD,  exp_rd[i],  i % 4, (i == 4) ? 1 : 0, 0, i, 10 + i, 1'b1);
    end
    check("t4.extra", q.size(), 0);

    // Backpressure on an ACT, then clear withdraws it.
    bus.out_ready = 1'b0;
    send_rd(2, 3, 16'h1234, 10'h55, 8'h77);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp.valid", bus.out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d.valid", k),    bus.out_valid, 1);
      check($sformatf("bp%0d.cmd", k),      bus.out_cmd, CMD_ACT);
      check($sformatf("bp%0d.cycle", k),    bus.out_cycle, HELD_ACT);
      check($sformatf("bp%0d.bg", k),       bus.out_bg, 2);
      check($sformatf("bp%0d.bank", k),     bus.out_bank, 3);
      check($sformatf("bp%0d.row", k),      bus.out_row, 16'h1234);
      check($sformatf("bp%0d.in_ready", k), bus.in_ready, 0);
      check($sformatf("bp%0d.busy", k),     busy, 1);
    end
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    check("clr.out_valid", bus.out_valid, 0);
    check("clr.busy",      busy, 0);
    clear = 1'b0;
    #1;
    check("clr.in_ready",  bus.in_ready, 1);
    check("clr.extra",     q.size(), 0);

    // Bank 0/0 was left open on row 1; after clear it must be closed again.
    bus.out_ready = 1'b1;
    send_rd(0, 0, 1, 2, 33);
    wait_idle();
    expect_cmd("t5.act", CMD_ACT, 0, 0, 0, 1, 0, 0, 1'b0);
    expect_cmd("t5.rd",  CMD_RD,  4, 0, 0, 0, 2, 33, 1'b1);
    check("t5.extra",    q.size(), 0);
    check("end.time_ovf", time_ovf, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
